clock_display_mux: RTL and testbench

- Downstream consumer of the three 2-digit BCD time counters (hours, minutes, seconds).
- Snapshots the packed BCD time once per frame and time-multiplexes it onto a 6-digit, common-anode 7-segment display (HH.MM.SS).
- Supports per-field blinking for set mode, hours-tens leading-zero blanking, and a dash glyph for invalid BCD digits.

---
 rtl/clock_display_mux_pkg.sv | 34 +++
 rtl/clock_display_mux_if.sv | 24 ++
 rtl/clock_display_mux_bcd_to_7seg.sv | 26 ++
 rtl/clock_display_mux.sv | 109 ++++++++++
 tb/tb_clock_display_mux.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/clock_display_mux_pkg.sv
// Shared constants for the HH.MM.SS multiplexed 7-segment display:
// active-low glyphs, digit count and field indices.
package clock_display_pkg;

  localparam int NUM_DIGITS = 6;

  localparam int FLD_SEC = 0;
  localparam int FLD_MIN = 1;
  localparam int FLD_HR  = 2;

  // Segment order {g,f,e,d,c,b,a}, a zero lights the segment
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic field_blinks(input logic [2:0] idx, input logic [2:0] mask);
    case (idx)
      3'd0, 3'd1: field_blinks = mask[FLD_SEC];
      3'd2, 3'd3: field_blinks = mask[FLD_MIN];
      3'd4, 3'd5: field_blinks = mask[FLD_HR];
      default:    field_blinks = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/clock_display_mux_if.sv
// Time-in / display-out bundle between the BCD time counters, the display
// multiplexer and the 7-segment panel.
interface clock_display_mux_if;
  import clock_display_pkg::*;

  logic [7:0] hours;
  logic [7:0] minutes;
  logic [7:0] seconds;
  logic [2:0] blink_mask;
  logic [NUM_DIGITS-1:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output hours, minutes, seconds, blink_mask,
    input  an, seg, dp
  );

  modport slave (
    input  hours, minutes, seconds, blink_mask,
    output an, seg, dp
  );

endinterface

// File: rtl/clock_display_mux_bcd_to_7seg.sv
// One BCD nibble to an active-low 7-segment glyph; non-decimal values
// render as a dash.
module bcd_to_7seg
  import clock_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/clock_display_mux.sv
// Scans a once-per-frame snapshot of the BCD time onto six common-anode
// digits, with live field blinking and hours-tens leading-zero blanking.
module clock_display_mux
  import clock_display_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64,
  parameter int LZ_BLANK     = 1
) (
  input  logic                 clk,
  input  logic                 preset,
  clock_display_mux_if.slave   bus
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [2:0] LAST_DIGIT = 3'(NUM_DIGITS - 1);

  logic [SCAN_W-1:0]     scan_cnt;
  logic [2:0]            digit_idx;
  logic [FRAME_W-1:0]    frame_cnt;
  logic                  blink_phase;
  logic [23:0]           snapshot;

  logic [3:0]            nib_p0;
  logic [6:0]            seg_dec_p0;
  logic [6:0]            seg_nxt_p0;
  logic [NUM_DIGITS-1:0] an_nxt_p0;
  logic                  dp_nxt_p0;
  logic                  blink_hit_p0;
  logic                  lz_hit_p0;

  logic [NUM_DIGITS-1:0] an_p1;
  logic [6:0]            seg_p1;
  logic                  dp_p1;

  logic scan_end;
  assign scan_end = (scan_cnt == SCAN_W'(SCAN_DIV - 1));

  // Stage p0: select the lit digit's nibble and resolve blanking
  always_comb begin
    case (digit_idx)
      3'd0:    nib_p0 = snapshot[3:0];
      3'd1:    nib_p0 = snapshot[7:4];
      3'd2:    nib_p0 = snapshot[11:8];
      3'd3:    nib_p0 = snapshot[15:12];
      3'd4:    nib_p0 = snapshot[19:16];
      3'd5:    nib_p0 = snapshot[23:20];
      default: nib_p0 = 4'h0;
    endcase
  end

  bcd_to_7seg u_dec (
    .bcd (nib_p0),
    .seg (seg_dec_p0)
  );

  // blink_mask is taken live so set-mode edits show up without waiting a frame
  always_comb begin
    blink_hit_p0 = blink_phase && field_blinks(digit_idx, bus.blink_mask);
    lz_hit_p0    = (LZ_BLANK != 0) && (digit_idx == LAST_DIGIT) && (nib_p0 == 4'h0);
    if (blink_hit_p0 || lz_hit_p0)
      seg_nxt_p0 = SEG_BLANK;
    else
      seg_nxt_p0 = seg_dec_p0;
    an_nxt_p0 = ~(NUM_DIGITS'(1) << digit_idx);
    dp_nxt_p0 = !((digit_idx == 3'd2) || (digit_idx == 3'd4));
  end

  // Stage p1: registered display drive plus scan/frame sequencing
  always_ff @(posedge clk or posedge preset) begin
    if (preset) begin
      an_p1       <= '1;
      seg_p1      <= SEG_BLANK;
      dp_p1       <= 1'b1;
      scan_cnt    <= '0;
      digit_idx   <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      snapshot    <= '0;
    end else begin
      an_p1  <= an_nxt_p0;
      seg_p1 <= seg_nxt_p0;
      dp_p1  <= dp_nxt_p0;
      if (scan_end) begin
        scan_cnt <= '0;
        if (digit_idx == LAST_DIGIT) begin
          digit_idx <= '0;
          snapshot  <= {bus.hours, bus.minutes, bus.seconds};
          if (frame_cnt == FRAME_W'(BLINK_FRAMES - 1)) begin
            frame_cnt   <= '0;
            blink_phase <= ~blink_phase;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end else begin
          digit_idx <= digit_idx + 3'd1;
        end
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
    end
  end

  assign bus.an  = an_p1;
  assign bus.seg = seg_p1;
  assign bus.dp  = dp_p1;

endmodule

// File: tb/tb_clock_display_mux.sv
// Scoreboard bench for clock_display_mux: stimulus queues per-digit expected
// glyphs frame by frame, a negedge monitor pops one entry per lit digit.
module tb_clock_display_mux;

  localparam int SCAN_DIV     = 4;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME_CYC    = SCAN_DIV * 6;

  logic clk;
  logic preset;

  clock_display_mux_if bus ();
  clock_display_mux_if bus_n ();

  assign bus_n.hours      = bus.hours;
  assign bus_n.minutes    = bus.minutes;
  assign bus_n.seconds    = bus.seconds;
  assign bus_n.blink_mask = bus.blink_mask;

  clock_display_mux #(.SCAN_DIV(SCAN_DIV), .BLINK_FRAMES(BLINK_FRAMES), .LZ_BLANK(1)) dut (
    .clk    (clk),
    .preset (preset),
    .bus    (bus)
  );

  clock_display_mux #(.SCAN_DIV(SCAN_DIV), .BLINK_FRAMES(BLINK_FRAMES), .LZ_BLANK(0)) dut_nolz (
    .clk    (clk),
    .preset (preset),
    .bus    (bus_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] an;
    logic [6:0] seg;
    logic [6:0] seg_n;
    logic       dp;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [6:0] d5, d4, d3, d2, d1, d0, n5, input int ndig);
    logic [6:0] s [6];
    s = '{d0, d1, d2, d3, d4, d5};
    for (int k = 0; k < ndig; k++) begin
      exp_t e;
      e.an    = ~(6'd1 << k);
      e.seg   = s[k];
      e.seg_n = (k == 5) ? n5 : s[k];
      e.dp    = !((k == 2) || (k == 4));
      q.push_back(e);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_dark(input string nm);
    check({nm, "_an"},    bus.an,    6'h3F);
    check({nm, "_seg"},   bus.seg,   7'h7F);
    check({nm, "_dp"},    bus.dp,    1);
    check({nm, "_an_n"},  bus_n.an,  6'h3F);
    check({nm, "_seg_n"}, bus_n.seg, 7'h7F);
    check({nm, "_dp_n"},  bus_n.dp,  1);
  endtask

  // Monitor: a change of an marks a new digit being presented
  logic [5:0] prev_an = 6'h3F;
  int         hold    = 0;
  bit         have    = 0;
  exp_t       cur;

  always @(negedge clk) begin
    if (preset) begin
      prev_an = 6'h3F;
      hold    = 0;
      have    = 0;
    end else begin
      if (bus.an != prev_an) begin
        if (prev_an != 6'h3F) check("digit_hold", hold, SCAN_DIV);
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          have = 0;
          $display("FAIL scoreboard_underflow: got an=0x%0h expected no new digit at %0t", bus.an, $time);
        end else begin
          cur  = q.pop_front();
          have = 1;
        end
        hold = 0;
      end
      hold++;
      if (have) begin
        check("an",     bus.an,     cur.an);
        check("seg",    bus.seg,    cur.seg);
        check("dp",     bus.dp,     cur.dp);
        check("an_n",   bus_n.an,   cur.an);
        check("seg_n",  bus_n.seg,  cur.seg_n);
        check("dp_n",   bus_n.dp,   cur.dp);
      end
      prev_an = bus.an;
    end
  end

  initial begin
    preset         = 1'b1;
    bus.hours      = 8'h00;
    bus.minutes    = 8'h00;
    bus.seconds    = 8'h00;
    bus.blink_mask = 3'b000;
    #2;
    check_dark("reset_dark");
    repeat (2) @(posedge clk);
    #3;
    check_dark("reset_hold");

    // Frame 0: reset snapshot, hours-tens blanked on the LZ instance only
    push_frame(7'h7F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 6);
    preset = 1'b0;
    wait_edges(1);
    check("first_an",  bus.an,  6'h3E);
    check("first_seg", bus.seg, 7'h40);
    bus.hours   = 8'h12;
    bus.minutes = 8'h34;
    bus.seconds = 8'h56;
    wait_edges(FRAME_CYC - 1);

    // Frame 1: 12.34.56
    push_frame(7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h79, 6);
    bus.seconds = 8'h59;
    wait_edges(FRAME_CYC);

    // Frame 2: 12.34.59, seconds rewritten while digit 3 is lit
    push_frame(7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h10, 7'h79, 6);
    wait_edges(3 * SCAN_DIV + 1);
    check("tear_digit3_lit", bus.an, 6'h37);
    bus.seconds = 8'h00;
    wait_edges(FRAME_CYC - 3 * SCAN_DIV - 1);

    // Frame 3: 12.34.00
    push_frame(7'h79, 7'h24, 7'h30, 7'h19, 7'h40, 7'h40, 7'h79, 6);
    bus.hours = 8'h07;
    wait_edges(FRAME_CYC);

    // Frames 4..7: 07.34.00 with minutes blinking, phase flips every 2 frames
    bus.blink_mask = 3'b010;
    push_frame(7'h7F, 7'h78, 7'h30, 7'h19, 7'h40, 7'h40, 7'h40, 6);
    wait_edges(FRAME_CYC);
    push_frame(7'h7F, 7'h78, 7'h30, 7'h19, 7'h40, 7'h40, 7'h40, 6);
    wait_edges(FRAME_CYC);
    push_frame(7'h7F, 7'h78, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40, 6);
    wait_edges(FRAME_CYC);
    push_frame(7'h7F, 7'h78, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40, 6);
    wait_edges(FRAME_CYC);

    // Frame 8: blinking off again, invalid minutes loaded for frame 9
    bus.blink_mask = 3'b000;
    push_frame(7'h7F, 7'h78, 7'h30, 7'h19, 7'h40, 7'h40, 7'h40, 6);
    bus.minutes = 8'hA5;
    wait_edges(FRAME_CYC);

    // Frame 9: 07.A5.00, tens-of-minutes shows a dash
    push_frame(7'h7F, 7'h78, 7'h3F, 7'h12, 7'h40, 7'h40, 7'h40, 6);
    wait_edges(FRAME_CYC);

    // Frame 10 interrupted by an asynchronous reset during digit 2
    push_frame(7'h7F, 7'h78, 7'h3F, 7'h12, 7'h40, 7'h40, 7'h40, 3);
    wait_edges(2 * SCAN_DIV + 2);
    #2;
    preset = 1'b1;
    #1;
    check_dark("midscan_dark");
    q.delete();
    wait_edges(2);
    push_frame(7'h7F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 6);
    #2;
    preset = 1'b0;
    wait_edges(1);
    check("restart_an",  bus.an,  6'h3E);
    check("restart_seg", bus.seg, 7'h40);
    wait_edges(FRAME_CYC - 1);
    push_frame(7'h7F, 7'h78, 7'h3F, 7'h12, 7'h40, 7'h40, 7'h40, 6);
    wait_edges(FRAME_CYC);
    #6;
    check("scoreboard_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
